// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: phase/strobe sequencer for a byte-serial AES-128 datapath
module aes_round_scheduler #(
    parameter int NUM_ROUNDS    = 10,
    parameter int KEYEXP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_en,
    output logic [3:0] byte_idx,
    output logic       col_last,
    output logic [3:0] round,
    output logic       key_step,
    output logic [7:0] rcon,
    output logic       sbox_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_KEYEXP = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0] KLAST      = 4'(KEYEXP_CYCLES - 1);
    logic [2:0] state;
    logic [3:0] kcnt;
    // phase sequencing; byte_idx wraps to 0 naturally when slot 15 completes a phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_idx <= 4'd0;
            round    <= 4'd0;
            rcon     <= 8'h01;
            kcnt     <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_LOAD;
                    byte_idx <= 4'd0;
                    round    <= 4'd0;
                    rcon     <= 8'h01;
                    kcnt     <= 4'd0;
                end
                S_LOAD: if (in_valid) begin
                    byte_idx <= byte_idx + 4'd1;
                    if (byte_idx == 4'd15) begin
                        state <= S_ROUND;
                        round <= 4'd0;
                    end
                end
                S_ROUND: begin
                    byte_idx <= byte_idx + 4'd1;
                    if (byte_idx == 4'd15) begin
                        if (round == LAST_ROUND) state <= S_OUTPUT;
                        else begin
                            round <= round + 4'd1;
                            kcnt  <= 4'd0;
                            state <= S_KEYEXP;
                        end
                    end
                end
                S_KEYEXP: begin
                    kcnt <= kcnt + 4'd1;
                    if (kcnt == KLAST) begin
                        state    <= S_ROUND;
                        byte_idx <= 4'd0;
                        kcnt     <= 4'd0;
                        rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    end
                end
                S_OUTPUT: if (out_ready) begin
                    byte_idx <= byte_idx + 4'd1;
                    if (byte_idx == 4'd15) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    // strobes decoded purely from registered state; load_en is the only input-dependent output
    always_comb begin
        in_ready  = state == S_LOAD;
        load_en   = in_valid && in_ready;
        ark_en    = state == S_ROUND;
        col_last  = ark_en && byte_idx[1:0] == 2'd3;
        sbox_en   = ark_en && round != 4'd0;
        mix_en    = sbox_en && round != LAST_ROUND;
        key_step  = state == S_KEYEXP;
        out_valid = state == S_OUTPUT;
        busy      = state != S_IDLE;
    end
endmodule
